data_mem_controller: RTL and testbench
======================================

// Module: data_mem_controller
// PURPOSE
//  Responder side of the per-thread data-memory valid/ready handshake issued by the compute cores' LSUs.
//  Arbitrates NUM_CONSUMERS read/write requesters onto NUM_CHANNELS external memory channels.
//  Relays each response back to the requesting consumer.
//  Sits between the cores' LSU ports and the data memory; the same block serves the
//  program-memory side with WRITE_ENABLE=0.
// PARAMETERS
//  ADDR_BITS      8  memory address width
//  DATA_BITS      8  memory data width
//  NUM_CONSUMERS  4  requesting LSUs (total threads across cores)
//  NUM_CHANNELS   1  concurrent memory channels, 1..NUM_CONSUMERS
//  WRITE_ENABLE   1  0 = read-only controller; all write logic removed
// PORTS
//  clk                    in   1                  clock
//  reset                  in   1                  asynchronous, active-high
//  consumer_read_valid    in   [NUM_CONSUMERS]    read request per consumer
//  consumer_read_address  in   [NUM_CONSUMERS][ADDR_BITS]
//  consumer_read_ready    out  [NUM_CONSUMERS]    read response valid
//  consumer_read_data     out  [NUM_CONSUMERS][DATA_BITS]
//  consumer_write_valid   in   [NUM_CONSUMERS]    write request per consumer
//  consumer_write_address in   [NUM_CONSUMERS][ADDR_BITS]
//  consumer_write_data    in   [NUM_CONSUMERS][DATA_BITS]
//  consumer_write_ready   out  [NUM_CONSUMERS]    write acknowledged
//  mem_read_valid         out  [NUM_CHANNELS]     read request to memory
//  mem_read_address       out  [NUM_CHANNELS][ADDR_BITS]
//  mem_read_ready         in   [NUM_CHANNELS]     memory read complete
//  mem_read_data          in   [NUM_CHANNELS][DATA_BITS]
//  mem_write_valid        out  [NUM_CHANNELS]     write request to memory
//  mem_write_address      out  [NUM_CHANNELS][ADDR_BITS]
//  mem_write_data         out  [NUM_CHANNELS][DATA_BITS]
//  mem_write_ready        in   [NUM_CHANNELS]     memory write complete
// BEHAVIOUR
//  Reset (async, active-high):
//   - every output, all channel states, claim mask and RR pointers -> 0 / IDLE
//   - an in-flight memory transaction is abandoned; no response is relayed
//  Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
//  IDLE:
//   - scan consumers starting at rr_ptr[ch], wrapping modulo NUM_CONSUMERS
//   - take the first consumer with a pending valid that no other channel has claimed
//   - within a consumer, read has priority over write
//   - same edge: set claim bit, latch consumer index, drive mem_*_valid=1 with address/data,
//     go to *_WAITING
//   - channels resolve in index order within one cycle; ch0 claims first, so no consumer
//     is granted to two channels
//  *_WAITING:
//   - hold mem_*_valid, address and data stable
//   - on mem_*_ready: mem_*_valid<=0; for reads, consumer_read_data<=mem_read_data;
//     consumer_*_ready<=1; go to *_RELAYING
//  *_RELAYING:
//   - hold consumer_*_ready=1 until the consumer's valid is sampled low
//   - then ready<=0, clear claim bit, rr_ptr[ch]<=served+1 (wrap), go to IDLE
//   - ready is therefore high 2 cycles with a compliant LSU, which drops valid on valid&&ready
//  Latency: consumer valid at edge 0 -> mem valid after edge 1; mem ready at edge k ->
//   consumer ready after edge k+1. Best-case round trip 3 cycles; channel free 2 cycles
//   after the response.
//  consumer_read_data holds its last value outside RELAYING.
//  Boundary conditions:
//   - consumer drops valid during WAITING: memory access still completes; ready pulses
//     1 cycle, then IDLE
//   - more requests than channels: the rest wait with valid held; nothing is dropped
//   - idle channels drive 0
//   - WRITE_ENABLE=0: mem_write_* and consumer_write_ready tied 0; write requests never served
// STRUCTURE
//  - gpu_mem_pkg: mem_chan_state_t enum (5 states, 3 bits)
//  - gpu_mem_pkg: function rr_next(idx, n) returning (idx+1) mod n
//  - sub-module mem_channel: one FSM with latched index/address/data plus mem-side handshake,
//    one instance per channel
//  - top level: arbitration scan, claim mask, consumer-side ready/data muxing
// TESTING
//  1. Single read: c2 reads addr 0x10, memory returns 0xAB after 2 cycles
//     -> c2 read_ready with data 0xAB; ready high exactly 2 cycles.
//  2. Write: c1 writes 0x5C to 0x20
//     -> mem_write addr 0x20 / data 0x5C; c1 write_ready after mem ready; no read activity.
//  3. Contention, NUM_CHANNELS=1: c0..c3 read simultaneously
//     -> served 0,1,2,3; then re-request all -> order continues from rr_ptr.
//  4. NUM_CHANNELS=2, 4 readers
//     -> ch0 takes c0 and ch1 takes c1 in the same cycle; never the same consumer.
//  5. c3 asserts read and write together -> read served first, write next.
//  6. Reset asserted while in READ_WAITING
//     -> all outputs 0 immediately; late mem_read_ready ignored; next request served normally.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the memory controller: channel FSM encoding
// and the round-robin pointer advance.
package gpu_mem_pkg;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } mem_chan_state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_channel.sv
// One memory channel: latches a granted request, runs the memory-side
// handshake, then holds the response until the consumer drops its valid.
module mem_channel
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1,
    parameter int IDX_BITS      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 grant_read,
    input  logic [IDX_BITS-1:0]  grant_idx,
    input  logic [ADDR_BITS-1:0] grant_addr,
    input  logic [DATA_BITS-1:0] grant_data,
    input  logic                 cons_read_valid,
    input  logic                 cons_write_valid,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output mem_chan_state_t      state,
    output logic [IDX_BITS-1:0]  idx,
    output logic [IDX_BITS-1:0]  rr_ptr,
    output logic                 release_claim,
    output logic                 read_load
);

    localparam bit WE = (WRITE_ENABLE != 0);

    mem_chan_state_t      state_next;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CH_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CH_IDLE: begin
                if (grant && grant_read)     state_next = CH_READ_WAITING;
                else if (grant && WE)        state_next = CH_WRITE_WAITING;
            end
            CH_READ_WAITING:   if (mem_read_ready)    state_next = CH_READ_RELAYING;
            CH_WRITE_WAITING:  if (mem_write_ready)   state_next = CH_WRITE_RELAYING;
            CH_READ_RELAYING:  if (!cons_read_valid)  state_next = CH_IDLE;
            CH_WRITE_RELAYING: if (!cons_write_valid) state_next = CH_IDLE;
            default:                                  state_next = CH_IDLE;
        endcase
    end

    // Request latch and round-robin pointer; the pointer moves past the
    // consumer just served only once its response has been consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            addr_q <= '0;
            data_q <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == CH_IDLE && grant) begin
                idx    <= grant_idx;
                addr_q <= grant_addr;
                data_q <= grant_data;
            end
            if (release_claim)
                rr_ptr <= IDX_BITS'(rr_next(32'(idx), NUM_CONSUMERS));
        end
    end

    always_comb begin
        mem_read_valid    = (state == CH_READ_WAITING);
        mem_read_address  = mem_read_valid ? addr_q : '0;
        mem_write_valid   = WE && (state == CH_WRITE_WAITING);
        mem_write_address = mem_write_valid ? addr_q : '0;
        mem_write_data    = mem_write_valid ? data_q : '0;
        release_claim     = ((state == CH_READ_RELAYING) && !cons_read_valid) ||
                            ((state == CH_WRITE_RELAYING) && !cons_write_valid);
        read_load         = (state == CH_READ_WAITING) && mem_read_ready;
    end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates LSU read/write requests onto memory channels with per-channel
// round-robin, and relays responses back to the owning consumer.
module data_mem_controller
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam bit WE       = (WRITE_ENABLE != 0);

    mem_chan_state_t      chan_state [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  chan_idx   [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  chan_rr    [NUM_CHANNELS];
    logic [IDX_BITS-1:0]  grant_idx  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] ch_ra      [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] ch_wa      [NUM_CHANNELS];
    logic [DATA_BITS-1:0] ch_wd      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_rv, ch_wv, chan_release, chan_load, grant_v, grant_rd;
    logic [NUM_CONSUMERS-1:0] claim_q, scan_taken, release_mask;
    logic [IDX_BITS-1:0]  cand;

    // Channels scan in index order; each grant is marked taken before the
    // next channel looks, so one consumer never lands on two channels.
    always_comb begin
        scan_taken = claim_q;
        grant_v    = '0;
        grant_rd   = '0;
        cand       = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_idx[ch] = '0;
            if (chan_state[ch] == CH_IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    cand = IDX_BITS'((int'(chan_rr[ch]) + k) % NUM_CONSUMERS);
                    if (!grant_v[ch] && !scan_taken[cand] &&
                        (consumer_read_valid[cand] || (WE && consumer_write_valid[cand]))) begin
                        grant_v[ch]   = 1'b1;
                        grant_rd[ch]  = consumer_read_valid[cand];
                        grant_idx[ch] = cand;
                    end
                end
                if (grant_v[ch]) scan_taken[grant_idx[ch]] = 1'b1;
            end
        end
    end

    always_comb begin
        release_mask = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            if (chan_release[ch]) release_mask[chan_idx[ch]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) claim_q <= '0;
        else       claim_q <= scan_taken & ~release_mask;
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        logic [ADDR_BITS-1:0] g_addr;
        assign g_addr = grant_rd[ch] ? consumer_read_address[grant_idx[ch]]
                                     : consumer_write_address[grant_idx[ch]];

        mem_channel #(
            .ADDR_BITS    (ADDR_BITS),
            .DATA_BITS    (DATA_BITS),
            .NUM_CONSUMERS(NUM_CONSUMERS),
            .WRITE_ENABLE (WRITE_ENABLE),
            .IDX_BITS     (IDX_BITS)
        ) u_chan (
            .clk              (clk),
            .reset            (reset),
            .grant            (grant_v[ch]),
            .grant_read       (grant_rd[ch]),
            .grant_idx        (grant_idx[ch]),
            .grant_addr       (g_addr),
            .grant_data       (consumer_write_data[grant_idx[ch]]),
            .cons_read_valid  (consumer_read_valid[chan_idx[ch]]),
            .cons_write_valid (consumer_write_valid[chan_idx[ch]]),
            .mem_read_valid   (ch_rv[ch]),
            .mem_read_address (ch_ra[ch]),
            .mem_read_ready   (mem_read_ready[ch]),
            .mem_write_valid  (ch_wv[ch]),
            .mem_write_address(ch_wa[ch]),
            .mem_write_data   (ch_wd[ch]),
            .mem_write_ready  (mem_write_ready[ch]),
            .state            (chan_state[ch]),
            .idx              (chan_idx[ch]),
            .rr_ptr           (chan_rr[ch]),
            .release_claim    (chan_release[ch]),
            .read_load        (chan_load[ch])
        );
    end

    always_comb begin
        mem_read_valid  = ch_rv;
        mem_write_valid = ch_wv;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_read_address[ch]  = ch_ra[ch];
            mem_write_address[ch] = ch_wa[ch];
            mem_write_data[ch]    = ch_wd[ch];
        end
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (chan_state[ch] == CH_READ_RELAYING)
                consumer_read_ready[chan_idx[ch]] = 1'b1;
            if (WE && chan_state[ch] == CH_WRITE_RELAYING)
                consumer_write_ready[chan_idx[ch]] = 1'b1;
        end
    end

    // Read data is registered per consumer and holds between responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            consumer_read_data <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++)
                if (chan_load[ch]) consumer_read_data[chan_idx[ch]] <= mem_read_data[ch];
        end
    end

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench: one single-channel controller and one dual-channel
// controller driven by hand-timed LSU and memory handshakes.
module tb_data_mem_controller;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]      c_rv, c_wv, c_rr, c_wr;
    logic [3:0][7:0] c_ra, c_wa, c_wd, c_rd;
    logic [0:0]      m_rv, m_rr, m_wv, m_wr;
    logic [0:0][7:0] m_ra, m_rd, m_wa, m_wd;

    logic [3:0]      c_rv_2, c_wv_2, c_rr_2, c_wr_2;
    logic [3:0][7:0] c_ra_2, c_wa_2, c_wd_2, c_rd_2;
    logic [1:0]      m_rv_2, m_rr_2, m_wv_2, m_wr_2;
    logic [1:0][7:0] m_ra_2, m_rd_2, m_wa_2, m_wd_2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_mem_controller #(.NUM_CHANNELS(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rd),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr)
    );

    data_mem_controller #(.NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv_2), .consumer_read_address(c_ra_2),
        .consumer_read_ready(c_rr_2), .consumer_read_data(c_rd_2),
        .consumer_write_valid(c_wv_2), .consumer_write_address(c_wa_2),
        .consumer_write_data(c_wd_2), .consumer_write_ready(c_wr_2),
        .mem_read_valid(m_rv_2), .mem_read_address(m_ra_2),
        .mem_read_ready(m_rr_2), .mem_read_data(m_rd_2),
        .mem_write_valid(m_wv_2), .mem_write_address(m_wa_2),
        .mem_write_data(m_wd_2), .mem_write_ready(m_wr_2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
        m_rr = '0; m_rd = '0; m_wr = '0;
        c_rv_2 = '0; c_wv_2 = '0; c_ra_2 = '0; c_wa_2 = '0; c_wd_2 = '0;
        m_rr_2 = '0; m_rd_2 = '0; m_wr_2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait (bounded) for the single-channel DUT to present a request.
    task automatic wait_mem1(input bit is_read);
        int n = 0;
        while ((is_read ? m_rv[0] : m_wv[0]) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(is_read ? "wait_mem_read" : "wait_mem_write", is_read ? m_rv[0] : m_wv[0], 1);
    endtask

    // Memory answers a read after `delay` cycles; the LSU drops valid one
    // cycle after seeing ready, so ready is seen high at exactly two samples.
    task automatic serve_read1(input int c, input logic [7:0] addr, input logic [7:0] data,
                               input int delay);
        wait_mem1(1'b1);
        check("rd_addr", m_ra[0], addr);
        check("rd_no_write", m_wv[0], 0);
        repeat (delay) tick();
        check("rd_hold_valid", m_rv[0], 1);
        m_rr[0] = 1'b1;
        m_rd[0] = data;
        tick();
        m_rr[0] = 1'b0;
        check("rd_ready", c_rr, 32'(1) << c);
        check("rd_data", c_rd[c], data);
        check("rd_mem_drop", m_rv[0], 0);
        tick();
        check("rd_ready_hold", c_rr, 32'(1) << c);
        c_rv[c] = 1'b0;
        tick();
        check("rd_ready_drop", c_rr, 0);
        check("rd_data_keep", c_rd[c], data);
    endtask

    task automatic serve_write1(input int c, input logic [7:0] addr, input logic [7:0] data,
                                input int delay);
        wait_mem1(1'b0);
        check("wr_addr", m_wa[0], addr);
        check("wr_data", m_wd[0], data);
        check("wr_no_read", m_rv[0], 0);
        repeat (delay) tick();
        m_wr[0] = 1'b1;
        tick();
        m_wr[0] = 1'b0;
        check("wr_ready", c_wr, 32'(1) << c);
        check("wr_mem_drop", m_wv[0], 0);
        check("wr_no_rd_ready", c_rr, 0);
        tick();
        check("wr_ready_hold", c_wr, 32'(1) << c);
        c_wv[c] = 1'b0;
        tick();
        check("wr_ready_drop", c_wr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check("rst_c_rr", c_rr, 0);
        check("rst_c_wr", c_wr, 0);
        check("rst_c_rd", c_rd, 0);
        check("rst_m_rv", m_rv, 0);
        check("rst_m_wv", m_wv, 0);
        check("rst_m_ra", m_ra, 0);
        check("rst_m_wa_wd", {m_wa, m_wd}, 0);
        check("rst_dut2", {c_rr_2, c_wr_2, m_rv_2, m_wv_2}, 0);

        // Single read: c2 @0x10, memory answers 2 cycles after the request.
        c_rv[2] = 1'b1; c_ra[2] = 8'h10;
        check("t1_no_early_valid", m_rv, 0);
        tick();
        check("t1_mem_valid", m_rv, 1);
        check("t1_mem_addr", m_ra[0], 8'h10);
        serve_read1(2, 8'h10, 8'hAB, 2);

        // Write: c1 writes 0x5C to 0x20.
        c_wv[1] = 1'b1; c_wa[1] = 8'h20; c_wd[1] = 8'h5C;
        serve_write1(1, 8'h20, 8'h5C, 1);

        // Read and write together from c3: read goes first.
        c_rv[3] = 1'b1; c_ra[3] = 8'h31;
        c_wv[3] = 1'b1; c_wa[3] = 8'h32; c_wd[3] = 8'h77;
        serve_read1(3, 8'h31, 8'h5A, 0);
        serve_write1(3, 8'h32, 8'h77, 0);

        // Contention on one channel: all four readers, round-robin order.
        do_reset();
        for (int c = 0; c < 4; c++) c_ra[c] = 8'h40 + 8'(c);
        c_rv = 4'hF;
        for (int c = 0; c < 4; c++) serve_read1(c, 8'h40 + 8'(c), 8'hC0 + 8'(c), 1);
        c_rv = 4'hF;
        for (int c = 0; c < 4; c++) serve_read1(c, 8'h40 + 8'(c), 8'hD0 + 8'(c), 0);
        c_rv[2] = 1'b1;
        serve_read1(2, 8'h42, 8'hE2, 0);
        c_rv = 4'hF;
        serve_read1(3, 8'h43, 8'hF3, 0);
        serve_read1(0, 8'h40, 8'hF0, 0);
        serve_read1(1, 8'h41, 8'hF1, 0);
        serve_read1(2, 8'h42, 8'hF2, 0);

        // Two channels, four readers: ch0 takes c0, ch1 takes c1 together.
        for (int c = 0; c < 4; c++) c_ra_2[c] = 8'h40 + 8'(c);
        c_rv_2 = 4'hF;
        tick();
        check("t4_both_valid", m_rv_2, 2'b11);
        check("t4_ch0_addr", m_ra_2[0], 8'h40);
        check("t4_ch1_addr", m_ra_2[1], 8'h41);
        m_rr_2 = 2'b11; m_rd_2[0] = 8'hA0; m_rd_2[1] = 8'hA1;
        tick();
        m_rr_2 = 2'b00;
        check("t4_ready_01", c_rr_2, 4'b0011);
        check("t4_data_01", {c_rd_2[1], c_rd_2[0]}, 16'hA1A0);
        tick();
        c_rv_2[0] = 1'b0; c_rv_2[1] = 1'b0;
        tick();
        check("t4_ready_drop", c_rr_2, 0);
        tick();
        check("t4_both_valid2", m_rv_2, 2'b11);
        check("t4_ch0_addr2", m_ra_2[0], 8'h42);
        check("t4_ch1_addr2", m_ra_2[1], 8'h43);
        m_rr_2 = 2'b11; m_rd_2[0] = 8'hB2; m_rd_2[1] = 8'hB3;
        tick();
        m_rr_2 = 2'b00;
        check("t4_ready_23", c_rr_2, 4'b1100);
        check("t4_data_23", {c_rd_2[3], c_rd_2[2]}, 16'hB3B2);
        tick();
        c_rv_2 = '0;
        tick();
        check("t4_idle", {c_rr_2, m_rv_2}, 0);

        // Reset while a read is outstanding; a late memory ready is ignored.
        c_rv[0] = 1'b1; c_ra[0] = 8'h33;
        tick();
        check("t6_waiting", m_rv, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_m_rv", m_rv, 0);
        check("t6_rst_m_ra", m_ra, 0);
        check("t6_rst_c_rd", c_rd, 0);
        c_rv[0] = 1'b0;
        m_rr[0] = 1'b1; m_rd[0] = 8'hEE;
        tick();
        reset = 1'b0;
        tick();
        check("t6_late_ready", c_rr, 0);
        check("t6_late_data", c_rd, 0);
        check("t6_late_m_rv", m_rv, 0);
        m_rr[0] = 1'b0;
        c_rv[1] = 1'b1; c_ra[1] = 8'h44;
        serve_read1(1, 8'h44, 8'h99, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
